// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared definitions for the data-memory load/store stage:
//            data word width, wait-state counter width and FSM encoding.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

  localparam int DMEM_WORD_W = 16;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : DEPTH x 16-bit storage, synchronous write, registered read.
//            When read and write are enabled on the same edge, the read
//            register captures the old word and the new word is stored.
// Ports    : clk      in   clock
//            rst      in   synchronous active-high reset (read register only)
//            i_we     in   write enable
//            i_re     in   read enable
//            i_idx    in   word index
//            i_wdata  in   write data
//            o_rdata  out  read register, held until the next read
// Revision : 1.0  initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_we,
  input  logic                   i_re,
  input  logic [AW-1:0]          i_idx,
  input  logic [DMEM_WORD_W-1:0] i_wdata,
  output logic [DMEM_WORD_W-1:0] o_rdata
);

  logic [DMEM_WORD_W-1:0] r_mem [DEPTH];
  logic [DMEM_WORD_W-1:0] r_rdata;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Non-blocking semantics give read-before-write on a shared edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_unit
// Purpose  : LW/SW load/store stage with a wait-state FSM that stalls the CPU
//            while an access is in flight. Word index = addr[AW:1].
// Ports    : clock      in   system clock
//            reset      in   synchronous active-high reset
//            mem_read   in   LW request
//            mem_write  in   SW request
//            addr       in   byte address
//            wdata      in   store data
//            rdata      out  load data, valid with done, held until next LW
//            stall      out  hold PC / suppress RegWrite
//            done       out  one-cycle completion pulse
//            misalign   out  odd-address flag with done (macro build only)
// Macro    : DMEM_MISALIGN_CHECK_EN enables odd-address detection; the
//            write is suppressed, rdata reads 0 and misalign pulses.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [DMEM_WORD_W-1:0] addr,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata,
  output logic                   stall,
  output logic                   done
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic                   misalign
`endif
);

  // The IDLE cycle that samples the request already counts as the first
  // wait state, so the WAIT phase lasts WAIT_CYCLES-1 cycles. With zero
  // wait states the array access happens at the sampling edge itself,
  // giving done exactly WAIT_CYCLES+1 cycles after the request.
  localparam logic [DMEM_CNT_W-1:0] c_CNT_LOAD =
    (WAIT_CYCLES > 0) ? DMEM_CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [DMEM_CNT_W-1:0] c_CNT_ONE = DMEM_CNT_W'(1);

  dmem_state_t            r_state, w_state_nxt;
  logic [DMEM_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic                   r_op_rd, r_op_wr, w_op_rd_nxt, w_op_wr_nxt;
  logic                   w_req;
  logic                   w_acc_en, w_acc_rd, w_acc_wr;
  logic                   w_odd;
  logic                   w_we, w_re;
  logic [DMEM_WORD_W-1:0] w_arr_rdata;
  logic                   w_unused;

  assign w_req = mem_read | mem_write;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_rd_nxt = r_op_rd;
    w_op_wr_nxt = r_op_wr;
    stall       = 1'b0;
    done        = 1'b0;
    w_acc_en    = 1'b0;
    w_acc_rd    = 1'b0;
    w_acc_wr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = w_req;
        if (w_req) begin
          // Latch the operation so an access already started completes
          // even if the request drops mid-operation.
          w_op_rd_nxt = mem_read;
          w_op_wr_nxt = mem_write;
          w_cnt_nxt   = c_CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            w_acc_en    = 1'b1;
            w_acc_rd    = mem_read;
            w_acc_wr    = mem_write;
            w_state_nxt = ST_DONE;
          end else if (WAIT_CYCLES == 1) begin
            w_state_nxt = ST_ACCESS;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall     = 1'b1;
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall       = 1'b1;
        w_acc_en    = 1'b1;
        w_acc_rd    = r_op_rd;
        w_acc_wr    = r_op_wr;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // Requests seen here are ignored; IDLE re-samples them next cycle.
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op_rd <= 1'b0;
      r_op_wr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op_rd <= w_op_rd_nxt;
      r_op_wr <= w_op_wr_nxt;
    end
  end

  assign w_we = w_acc_wr & ~w_odd;
  assign w_re = w_acc_rd & ~w_odd;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clock),
    .rst     (reset),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (addr[AW:1]),
    .i_wdata (wdata),
    .o_rdata (w_arr_rdata)
  );

`ifdef DMEM_MISALIGN_CHECK_EN
  logic r_mis;
  logic r_zero;

  assign w_odd = addr[0];

  // r_zero forces rdata to 0 after a misaligned access until the next
  // aligned load refreshes the array read register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mis  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_acc_en) begin
      r_mis <= addr[0];
      if (addr[0]) begin
        r_zero <= 1'b1;
      end else if (w_re) begin
        r_zero <= 1'b0;
      end
    end
  end

  assign rdata    = r_zero ? '0 : w_arr_rdata;
  assign misalign = done & r_mis;
`else
  assign w_odd = 1'b0;
  assign rdata = w_arr_rdata;
`endif

  // Upper address bits wrap by design; addr[0] is ignored in the base build.
  assign w_unused = &{1'b0, addr[DMEM_WORD_W-1:AW+1], addr[0]};

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_unit
// Purpose  : Scoreboard bench for data_mem_unit. A driver issues LW/SW
//            requests and pushes expected results computed from a plain
//            word-array model; a monitor pops and compares on every done.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_unit;

  localparam int WC    = 2;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        stall;
  logic        done;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  always #5 clock = ~clock;

  data_mem_unit #(
    .DEPTH       (DEPTH),
    .AW          (AW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .done      (done)
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    .misalign  (misalign)
`endif
  );

  typedef struct {
    logic [15:0] rdata;
    logic        mis;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model [DEPTH];
  logic [15:0] model_rdata = '0;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          stall_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clock) begin
    if (reset) begin
      stall_run = 0;
    end else begin
      if (stall) stall_run++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rdata", {16'd0, rdata}, {16'd0, mon_e.rdata});
          check("latency", cyc - mon_e.issue, WC + 1);
          check("stall_cycles", stall_run, WC + 1);
          check("stall_low_at_done", {31'd0, stall}, 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
          check("misalign", {31'd0, misalign}, {31'd0, mon_e.mis});
`endif
        end
        stall_run = 0;
      end
    end
  end

  // early=1: called in the DONE cycle of the previous access, so the new
  // request is held through DONE and is only sampled in the next cycle.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input bit early);
    exp_t           e;
    logic [AW-1:0]  idx;
    bit             odd;
    int             n;
    if (!early) begin
      @(posedge clock);
      #1;
    end
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    idx       = a[AW:1];
`ifdef DMEM_MISALIGN_CHECK_EN
    odd = a[0];
`else
    odd = 1'b0;
`endif
    if (odd) begin
      model_rdata = '0;
    end else begin
      if (rd) model_rdata = model[idx];
      if (wr) model[idx] = d;
    end
    e.rdata = model_rdata;
    e.mis   = odd;
    e.issue = early ? cyc + 1 : cyc;
    sb.push_back(e);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!done && n < 40);
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    bit nxt_early;
    bit b2b;
    logic rd, wr;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rdata", {16'd0, rdata}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Define every word so later loads have known contents.
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 1'b1, 16'(i * 2), 16'(i * 16'h0101) ^ 16'h5A5A, 1'b0);
      idle();
    end

    // Basic SW then LW
    access(1'b0, 1'b1, 16'h0004, 16'h1234, 1'b0); idle();
    access(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0); idle();
    access(1'b0, 1'b1, 16'h0010, 16'h00FF, 1'b0); idle();
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0); idle();
    // Address wrap
    access(1'b0, 1'b1, 16'h0202, 16'hBEEF, 1'b0); idle();
    access(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0); idle();

    // Reset during WAIT aborts the store
    access(1'b0, 1'b1, 16'h0006, 16'h5555, 1'b0); idle();
    @(posedge clock);
    #1;
    mem_write = 1'b1; addr = 16'h0006; wdata = 16'hAAAA;
    @(posedge clock);
    #1;
    check("stall_in_wait", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    mem_write = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_rdata = '0;
    check("stall_after_reset", {31'd0, stall}, 32'd0);
    check("done_after_reset", {31'd0, done}, 32'd0);
    check("rdata_after_reset", {16'd0, rdata}, 32'd0);
    access(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0); idle();

    // Read-before-write
    access(1'b0, 1'b1, 16'h0008, 16'h0001, 1'b0); idle();
    access(1'b1, 1'b1, 16'h0008, 16'h0002, 1'b0); idle();
    access(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0); idle();

    // Request held during DONE is only taken in the following IDLE cycle
    access(1'b0, 1'b1, 16'h0020, 16'hC0DE, 1'b0);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1); idle();

`ifdef DMEM_MISALIGN_CHECK_EN
    access(1'b0, 1'b1, 16'h0009, 16'hFFFF, 1'b0); idle();
    access(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0); idle();
`endif

    // Randomised traffic
    nxt_early = 1'b0;
    for (int k = 0; k < 150; k++) begin
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      b2b = ($urandom_range(0, 3) == 0);
      access(rd, wr, 16'($urandom), 16'($urandom), nxt_early);
      nxt_early = b2b;
      if (!b2b) begin
        idle();
        repeat ($urandom_range(0, 2)) @(posedge clock);
      end
    end
    idle();

    repeat (6) @(posedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
